// File: rtl/coproc_sequencer.sv
// In-order issue/commit/result sequencer between the CV32E40X eXtension interface
// and a single coprocessor execution unit.
module coproc_sequencer #(
  parameter int unsigned X_ID_WIDTH = 4,
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [X_ID_WIDTH-1:0] issue_id_i,
  input  logic [31:0]           issue_instr_i,
  input  logic [XLEN-1:0]       issue_rs0_i,
  input  logic [XLEN-1:0]       issue_rs1_i,
  output logic                  issue_accept_o,
  output logic                  issue_writeback_o,
  input  logic                  commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  output logic                  exec_valid_o,
  input  logic                  exec_ready_i,
  output logic                  exec_op_o,
  output logic [XLEN-1:0]       exec_rs0_o,
  output logic [XLEN-1:0]       exec_rs1_o,
  input  logic                  exec_done_i,
  input  logic [XLEN-1:0]       exec_data_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [X_ID_WIDTH-1:0] result_id_o,
  output logic [4:0]            result_rd_o,
  output logic [XLEN-1:0]       result_data_o,
  output logic                  result_we_o,
  output logic                  busy_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [6:0] OPC_TEST = 7'h0a;
  localparam logic [6:0] OPC_ADD  = 7'h0b;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  op;
    logic [4:0]            rd;
    logic [XLEN-1:0]       rs0;
    logic [XLEN-1:0]       rs1;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_WAIT,
    ST_RESULT
  } state_t;

  state_t          state_q, state_d;
  entry_t          mem [DEPTH];
  logic [DEPTH-1:0] occ_q, cmt_q, kil_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [XLEN-1:0] data_q;

  logic   push, pop_c, latch_c, known_op, same_cycle_commit;
  entry_t new_entry, head;
  logic   head_occ, head_cmt, head_kil;

  logic unused_instr;
  assign unused_instr = ^issue_instr_i[31:12];

  // Issue decode and handshake
  assign known_op          = (issue_instr_i[6:0] == OPC_TEST) | (issue_instr_i[6:0] == OPC_ADD);
  assign issue_ready_o     = ~rst_i & (count_q < CW'(DEPTH));
  assign issue_accept_o    = ~rst_i & issue_valid_i & known_op;
  assign issue_writeback_o = issue_accept_o;
  assign push              = issue_valid_i & issue_ready_o & issue_accept_o;
  assign same_cycle_commit = commit_valid_i & (commit_id_i == issue_id_i);

  assign new_entry.id  = issue_id_i;
  assign new_entry.op  = (issue_instr_i[6:0] == OPC_ADD);
  assign new_entry.rd  = issue_instr_i[11:7];
  assign new_entry.rs0 = issue_rs0_i;
  assign new_entry.rs1 = issue_rs1_i;

  assign head     = mem[rd_ptr_q];
  assign head_occ = occ_q[rd_ptr_q];
  assign head_cmt = cmt_q[rd_ptr_q];
  assign head_kil = kil_q[rd_ptr_q];

  // Payload storage; occupancy is tracked separately so it needs no reset
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= new_entry;
  end

  // Queue bookkeeping and per-ID commit/kill tracking
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q    <= '0;
      cmt_q    <= '0;
      kil_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (commit_valid_i && occ_q[i] && (mem[i].id == commit_id_i)) begin
          cmt_q[i] <= 1'b1;
          if (commit_kill_i) kil_q[i] <= 1'b1;
        end
      end
      if (push) begin
        occ_q[wr_ptr_q] <= 1'b1;
        cmt_q[wr_ptr_q] <= same_cycle_commit;
        kil_q[wr_ptr_q] <= same_cycle_commit & commit_kill_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_c) begin
        occ_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop_c);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Head-of-queue sequencing; kills only matter while the head is still idle
  always_comb begin
    state_d        = state_q;
    pop_c          = 1'b0;
    latch_c        = 1'b0;
    exec_valid_o   = 1'b0;
    result_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (head_occ && head_cmt) begin
          if (head_kil) pop_c   = 1'b1;
          else          state_d = ST_DISPATCH;
        end
      end
      ST_DISPATCH: begin
        exec_valid_o = 1'b1;
        if (exec_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (exec_done_i) begin
          latch_c = 1'b1;
          state_d = ST_RESULT;
        end
      end
      ST_RESULT: begin
        result_valid_o = 1'b1;
        if (result_ready_i) begin
          pop_c   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)        data_q <= '0;
    else if (latch_c) data_q <= exec_data_i;
  end

  // Fields are forced to zero outside their valid phase so reset leaves all outputs low
  assign exec_op_o     = exec_valid_o & head.op;
  assign exec_rs0_o    = exec_valid_o ? head.rs0 : '0;
  assign exec_rs1_o    = exec_valid_o ? head.rs1 : '0;
  assign result_id_o   = result_valid_o ? head.id : '0;
  assign result_rd_o   = result_valid_o ? head.rd : '0;
  assign result_data_o = result_valid_o ? data_q : '0;
  assign result_we_o   = result_valid_o & (head.rd != 5'd0);
  assign busy_o        = (count_q != '0) | (state_q != ST_IDLE);

endmodule
